// File: rtl/rtp_result_monitor.sv
// rtl/rtp_result_monitor.sv - round-robin merge of ray hit results into one FIFO, with run control and statistics
module rtp_result_monitor #(
    parameter int              N_CH   = 2,
    parameter int              ID_W   = 32,
    parameter int              T_W    = 32,
    parameter int              DEPTH  = 8,
    parameter int              CNT_W  = 64,
    parameter logic [T_W-1:0]  MISS_T = 32'h7F7FFFFF,
    localparam int             CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ID_W-1:0]      ray_total,
    input  logic [31:0]          timeout_limit,
    input  logic                 rtp_finish,
    input  logic [N_CH-1:0]      ch_valid,
    output logic [N_CH-1:0]      ch_ready,
    input  logic [N_CH*ID_W-1:0] ch_ray_id,
    input  logic [N_CH*T_W-1:0]  ch_hitT,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_ray_id,
    output logic [T_W-1:0]       out_hitT,
    output logic [CH_W-1:0]      out_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [ID_W-1:0]      result_count,
    output logic [ID_W-1:0]      miss_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int E_W   = CH_W + ID_W + T_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [ID_W-1:0]    result_count_q, result_count_d;
    logic [ID_W-1:0]    miss_count_q, miss_count_d;
    logic [31:0]        idle_q, idle_d;
    logic [E_W-1:0]     mem_q [DEPTH];
    logic [E_W-1:0]     mem_d [DEPTH];

    logic               grant_any;
    logic [CH_W-1:0]    grant_idx;
    logic [CH_W-1:0]    cand;
    logic               fifo_full;
    logic               accept;
    logic               pop;
    logic               start_ok;
    logic               run_active;
    logic [ID_W-1:0]    sel_id;
    logic [T_W-1:0]     sel_hit;

    // Scan from the highest offset down so the nearest valid channel at/after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = CH_W'((int'(rr_ptr_q) + k) % N_CH);
            if (ch_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        fifo_full  = (count_q == CW'(DEPTH));
        accept     = (state_q == S_RUN) && !fifo_full && grant_any;
        pop        = (count_q != '0) && out_ready;
        start_ok   = start && (state_q != S_RUN) && (state_q != S_DRAIN);
        run_active = (state_q == S_RUN) || (state_q == S_DRAIN);
        sel_id     = ch_ray_id[int'(grant_idx)*ID_W +: ID_W];
        sel_hit    = ch_hitT[int'(grant_idx)*T_W +: T_W];
        ch_ready   = '0;
        if (accept) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // Storage and statistics; a start from a non-busy state flushes everything.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        cycle_count_d  = cycle_count_q;
        result_count_d = result_count_q;
        miss_count_d   = miss_count_q;
        idle_d         = idle_q;
        if (start_ok) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            cycle_count_d  = '0;
            result_count_d = '0;
            miss_count_d   = '0;
            idle_d         = '0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = {grant_idx, sel_id, sel_hit};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (run_active && cycle_count_q != '1) begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
            end
            if (accept && result_count_q != '1) begin
                result_count_d = result_count_q + ID_W'(1);
            end
            if (accept && sel_hit == MISS_T && miss_count_q != '1) begin
                miss_count_d = miss_count_q + ID_W'(1);
            end
            if (state_q == S_RUN) begin
                if (accept) begin
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 32'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (rtp_finish || (ray_total != '0 && result_count_d >= ray_total)) begin
                    state_d = S_DRAIN;
                end else if (timeout_limit != '0 && idle_d >= timeout_limit) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
        endcase
        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        timeout_d = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            rr_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            cycle_count_q  <= '0;
            result_count_q <= '0;
            miss_count_q   <= '0;
            idle_q         <= '0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            rr_ptr_q       <= rr_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            cycle_count_q  <= cycle_count_d;
            result_count_q <= result_count_d;
            miss_count_q   <= miss_count_d;
            idle_q         <= idle_d;
        end
        mem_q <= mem_d;
    end

    assign out_valid                        = (count_q != '0);
    assign {out_ch, out_ray_id, out_hitT}   = mem_q[rd_ptr_q];
    assign busy                             = busy_q;
    assign done                             = done_q;
    assign timeout                          = timeout_q;
    assign cycle_count                      = cycle_count_q;
    assign result_count                     = result_count_q;
    assign miss_count                       = miss_count_q;

endmodule
